ps2_cmd_tx: RTL
===============

Name: ps2_cmd_tx

Overview:
PS/2 host-to-device command transmitter for the synth's keyboard port. It sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xF4 (enable). It drives the open-drain PS2_CLK/PS2_DAT lines through output-enable controls and reports the device ACK. It sits beside the existing PS/2 receive path in the top level and shares its pins.

Parameters:
INHIBIT_CYCLES, 5000, clock-low inhibit time in CLOCK_50 cycles (100 us).
START_CYCLES, 50, cycles data is held low with clock still low before clock release (1 us).
TIMEOUT_CYCLES, 750000, max cycles from clock release to end of ACK (15 ms).
SYNC_STAGES, 2, synchroniser depth on ps2_clk_in/ps2_dat_in (>=2).

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_byte  in  8  command byte, LSB sent first
cmd_ready  out  1  high in IDLE only; transfer accepted when cmd_valid&cmd_ready
ps2_clk_in  in  1  raw PS2_CLK pin value
ps2_dat_in  in  1  raw PS2_DAT pin value
ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (top: PS2_CLK = oe ? 0 : z)
ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release
tx_active  out  1  high from accept to done; receiver ignores the bus while high
done  out  1  one-cycle pulse at end of every accepted command
ack_ok  out  1  valid with done: 1 = device ACKed
error  out  1  valid with done: 1 = no ACK or timeout

Behaviour:
- Reset, asynchronous on resetn low: state IDLE. ps2_clk_oe=0, ps2_dat_oe=0, cmd_ready=1, tx_active=0, done=0, ack_ok=0, error=0, counters 0. Lines are released immediately, including mid-transfer.
- Inputs pass through SYNC_STAGES flops. fall = prev_sync_clk & ~sync_clk, one cycle wide.
- Shift register (11 bits) is loaded on accept: {stop=1, parity, cmd_byte}. parity = ~^cmd_byte (odd parity).
- IDLE: when cmd_valid&cmd_ready, latch cmd_byte and go to INHIBIT. tx_active=1 from the next cycle.
- INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: clk_oe=1, dat_oe=1 (start bit 0) for START_CYCLES cycles. Then clk_oe=0, timeout counter cleared, go to SHIFT.
- SHIFT: falling-edge index n counts 1..10.
  - Falls 1-8: dat_oe = ~data bit (n-1).
  - Fall 9: dat_oe = ~parity.
  - Fall 10: dat_oe=0 (stop bit / release).
  - After fall 10, go to ACK.
  - dat_oe holds the start bit until fall 1.
- ACK: on the next fall, sample sync_dat. 0 → ack_ok=1; 1 → error=1. Go to WAIT_IDLE.
- WAIT_IDLE: wait until sync_clk=1 and sync_dat=1 together, then go to DONE.
- DONE: single-cycle done pulse with ack_ok/error; tx_active=0. ack_ok/error hold until the next accept, which clears both. Return to IDLE.
- Timeout: counter runs in SHIFT, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES forces clk_oe=0, dat_oe=0, error=1, ack_ok=0, then DONE. Timeout wins over a fall in the same cycle.
- cmd_valid while not in IDLE: ignored, no queuing. The command is not lost only if the requester holds cmd_valid.
- A fall during INHIBIT/START (device glitch) is ignored.
- Counters are sized by $clog2 of their parameter and saturate at terminal count.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE);
  - command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA.
- One sub-module, ps2_line_sync: parameterised synchroniser plus falling-edge detector. It is reused by the receive path.

Test Plan:
- cmd_byte=0xED, device model ACKs:
  - clk_oe high exactly 5000 cycles, then dat_oe high with clk_oe for 50 cycles;
  - bits driven 1,0,1,1,0,1,1,1;
  - parity 1, stop released;
  - done pulse with ack_ok=1, error=0.
- cmd_byte=0xF4: bits on the line 0,0,1,0,1,1,1,1; parity bit 0; ACK → ack_ok=1.
- Device leaves data high at fall 11: done pulse with ack_ok=0, error=1; both oe low.
- Device never clocks after release: exactly 750000 cycles after clk_oe falls, done pulses with error=1; lines released.
- resetn low after fall 4: both oe=0 in the same cycle (asynchronous), cmd_ready=1, no done pulse. A new 0xFF then completes normally.
- cmd_valid pulsed with 0x00 during SHIFT of 0xED: ignored, and the transmitted byte stays 0xED.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS2_CLK/PS2_DAT pins and flags falling edges of the clock.
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall
);

  logic [STAGES-1:0] clk_pipe;
  logic [STAGES-1:0] dat_pipe;
  logic              prev_clk;

  // Pipes reset to 1 because an idle PS/2 bus sits high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_pipe <= '1;
      dat_pipe <= '1;
      prev_clk <= 1'b1;
    end else begin
      clk_pipe <= {clk_pipe[STAGES-2:0], clk_in};
      dat_pipe <= {dat_pipe[STAGES-2:0], dat_in};
      prev_clk <= clk_pipe[STAGES-1];
    end
  end

  assign sync_clk = clk_pipe[STAGES-1];
  assign sync_dat = dat_pipe[STAGES-1];
  assign fall     = prev_clk & ~sync_clk;

endmodule

// File: rtl/ps2_cmd_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift out
// one byte on device clock falls, then collect the device ACK bit.
module ps2_cmd_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_active,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PHASE_W-1:0] INH_LAST   = PHASE_W'(INHIBIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] START_LAST = PHASE_W'(START_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t         state;
  logic [PHASE_W-1:0] phase_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [3:0]         bit_cnt;
  logic [10:0]        shift;
  logic               sync_clk;
  logic               sync_dat;
  logic               fall;
  logic               timeout;

  ps2_line_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .sync_clk (sync_clk),
    .sync_dat (sync_dat),
    .fall     (fall)
  );

  assign timeout = (to_cnt == TO_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      cmd_ready  <= 1'b1;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
      phase_cnt  <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            shift      <= {1'b1, odd_parity(cmd_byte), cmd_byte};
            ack_ok     <= 1'b0;
            error      <= 1'b0;
            cmd_ready  <= 1'b0;
            tx_active  <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            phase_cnt  <= '0;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (phase_cnt == INH_LAST) begin
            ps2_dat_oe <= 1'b1;
            phase_cnt  <= '0;
            state      <= START;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        START: begin
          if (phase_cnt == START_LAST) begin
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // Once the clock is handed to the device, a stalled device must not
        // hang the port, so the timeout takes priority over any clock fall.
        SHIFT, ACK, WAIT_IDLE: begin
          if (timeout) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            ack_ok     <= 1'b0;
            error      <= 1'b1;
            done       <= 1'b1;
            tx_active  <= 1'b0;
            state      <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            case (state)
              SHIFT: begin
                if (fall) begin
                  ps2_dat_oe <= ~shift[0];
                  shift      <= {1'b0, shift[10:1]};
                  bit_cnt    <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd9) state <= ACK;
                end
              end
              ACK: begin
                if (fall) begin
                  if (sync_dat) error  <= 1'b1;
                  else          ack_ok <= 1'b1;
                  state <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (sync_clk && sync_dat) begin
                  done      <= 1'b1;
                  tx_active <= 1'b0;
                  state     <= DONE;
                end
              end
              default: ;
            endcase
          end
        end

        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
